// File: rtl/rv_pkg.sv
// Shared RV32I constants used by the register file,
// the decoder and the writeback scheduler.
package rv_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int NREG   = 32;

  localparam logic [REG_AW-1:0] REG_X0 = '0;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant, rotating
// pointer moves past the winner on every grant.
module rr_arbiter #(
  parameter int N = 2,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);

  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_nxt;
  logic          found;
  int            idx;

  always_comb begin
    gnt     = '0;
    ptr_nxt = ptr;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        ptr_nxt  = PW'((idx + 1) % N);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else begin
      ptr <= ptr_nxt;
    end
  end

endmodule

// File: rtl/rf_wb_scheduler.sv
// RF write-port scheduler: round-robin writeback
// arbitration, registered RF write and busy scoreboard.
module rf_wb_scheduler #(
  parameter int NREQ   = 2,
  parameter int XLEN   = rv_pkg::XLEN,
  parameter int REG_AW = rv_pkg::REG_AW
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   issue_valid,
  input  logic                   issue_we,
  input  logic [REG_AW-1:0]      issue_rs1,
  input  logic [REG_AW-1:0]      issue_rs2,
  input  logic [REG_AW-1:0]      issue_rd,
  output logic                   issue_stall,
  input  logic [NREQ-1:0]        wb_valid,
  input  logic [NREQ*REG_AW-1:0] wb_rd,
  input  logic [NREQ*XLEN-1:0]   wb_data,
  output logic [NREQ-1:0]        wb_ready,
  output logic                   rf_we,
  output logic [REG_AW-1:0]      rf_rd,
  output logic [XLEN-1:0]        rf_indata,
  output logic [31:0]            busy_mask,
  output logic                   wb_err
);

  import rv_pkg::*;

  logic [NREG-1:0]   busy;
  logic [NREG-1:0]   busy_nxt;
  logic [NREG-1:0]   set_vec;
  logic [NREG-1:0]   clr_vec;
  logic [NREQ-1:0]   gnt;
  logic              hs;
  logic [REG_AW-1:0] g_rd;
  logic [XLEN-1:0]   g_data;
  logic              g_busy;
  logic              accept;
  logic              err_nxt;

  rr_arbiter #(.N(NREQ)) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (wb_valid),
    .gnt   (gnt)
  );

  assign wb_ready  = gnt;
  assign hs        = |gnt;
  assign busy_mask = busy;

  always_comb begin
    g_rd   = '0;
    g_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        g_rd   = g_rd | wb_rd[i*REG_AW +: REG_AW];
        g_data = g_data | wb_data[i*XLEN +: XLEN];
      end
    end
  end

  assign issue_stall = issue_valid &
                       (busy[issue_rs1] |
                        busy[issue_rs2] |
                        (issue_we & busy[issue_rd]));
  assign accept = issue_valid & ~issue_stall;

  // A producer committing this cycle no longer counts,
  // so a second writeback to the same rd is flagged.
  assign g_busy = busy[g_rd] &
                  ~(rf_we && (rf_rd == g_rd));
  assign err_nxt = wb_err |
                   (hs & (g_rd != REG_X0) & ~g_busy);

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (accept && issue_we && issue_rd != REG_X0) begin
      set_vec = NREG'(1) << issue_rd;
    end
    if (rf_we) begin
      clr_vec = NREG'(1) << rf_rd;
    end
    // set after clear: a new producer keeps the bit
    busy_nxt = ((busy & ~clr_vec) | set_vec) &
               ~NREG'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
      wb_err <= 1'b0;
    end else begin
      busy <= busy_nxt;
      wb_err <= err_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we     <= 1'b0;
      rf_rd     <= '0;
      rf_indata <= '0;
    end else if (hs) begin
      rf_we     <= (g_rd != REG_X0);
      rf_rd     <= g_rd;
      rf_indata <= g_data;
    end else begin
      rf_we     <= 1'b0;
    end
  end

endmodule
